fabric_config_loader: RTL and testbench

- Configuration writer for the fabric: receives a serial bitstream and deserializes it into per-resource config words.
- Writes each word into a logic-tile LUT memory (33 bits: 32 truth-table bits plus registered/combinational select bit 32) or a 4x4 switch-box crosspoint register (16 bits).
- Sits between the external programming pin and the fabric's config write port.
- Signals completion so user logic may start.

---
 rtl/fabric_cfg_pkg.sv | 30 +++
 rtl/fabric_config_loader_cfg_bit_deserializer.sv | 41 ++++
 rtl/fabric_config_loader.sv | 124 ++++++++++++
 tb/tb_fabric_config_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared framing constants, field widths and FSM state codes for the fabric config loader.
package fabric_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] END_ADDR  = 8'hFF;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 33;
  localparam int DEF_TILE_CFG_W = 33;
  localparam int DEF_SW_CFG_W   = 16;

  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_WRITE = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic {
    SEL_TILE   = 1'b0,
    SEL_SWITCH = 1'b1
  } cfg_sel_e;

  // Even parity over a whole frame body (addr, data and the parity bit itself).
  function automatic logic frame_parity_ok(input logic [ADDR_W+DATA_W:0] i_bits);
    return ~(^i_bits);
  endfunction

endpackage

// File: rtl/fabric_config_loader_cfg_bit_deserializer.sv
// MSB-first shift register with a bit counter; o_last flags the final bit of the field.
module cfg_bit_deserializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_shift,
  input  logic         i_bit,
  output logic [W-1:0] o_data,
  output logic         o_last
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sh;
  logic          w_full;

  assign w_full = (r_cnt == CW'(W));
  assign o_last = (r_cnt == CW'(W - 1));
  assign o_data = r_sh;

  // Shift accepted bits in; a full field ignores further shifts until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_shift && !w_full) begin
      r_sh  <= {r_sh[W-2:0], i_bit};
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_sh  <= r_sh;
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/fabric_config_loader.sv
// Serial configuration loader: hunts for the sync byte, collects addr/data/parity,
// validates the frame and issues one write strobe per good frame.
module fabric_config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_TILES    = 24,
  parameter int NUM_SWITCHES = 9,
  parameter int TILE_CFG_W   = DEF_TILE_CFG_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  bs_data,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  input  logic                  restart,
  output logic                  cfg_we,
  output logic                  cfg_sel,
  output logic [6:0]            cfg_index,
  output logic [TILE_CFG_W-1:0] cfg_data,
  output logic                  cfg_done,
  output logic                  cfg_error,
  output logic [7:0]            frame_count
);

  logic [2:0]            r_state, w_next;
  logic [7:0]            r_hunt, w_hunt_next;
  logic                  r_ready, r_we, r_sel, r_done, r_error, r_par;
  logic [6:0]            r_index;
  logic [TILE_CFG_W-1:0] r_data, w_data;
  logic [7:0]            r_count;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_xfer, w_clr, w_addr_last, w_data_last;
  logic                  w_par_ok, w_is_end, w_in_range;

  assign w_xfer      = bs_valid && r_ready;
  assign w_hunt_next = {r_hunt[6:0], bs_data};
  assign w_clr       = restart || (r_state == ST_SYNC);
  assign w_par_ok    = frame_parity_ok({w_addr, w_data, r_par});
  assign w_is_end    = (w_addr == END_ADDR);
  assign w_in_range  = w_addr[7] ? ({25'd0, w_addr[6:0]} < NUM_SWITCHES)
                                 : ({25'd0, w_addr[6:0]} < NUM_TILES);

  cfg_bit_deserializer #(.W(ADDR_W)) u_addr (
    .clk(clock), .rst_n(reset_n), .i_clr(w_clr),
    .i_shift(w_xfer && (r_state == ST_ADDR)), .i_bit(bs_data),
    .o_data(w_addr), .o_last(w_addr_last)
  );

  cfg_bit_deserializer #(.W(TILE_CFG_W)) u_data (
    .clk(clock), .rst_n(reset_n), .i_clr(w_clr),
    .i_shift(w_xfer && (r_state == ST_DATA)), .i_bit(bs_data),
    .o_data(w_data), .o_last(w_data_last)
  );

  // Next-state decode; restart overrides everything, including a same-cycle bit transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SYNC:  if (w_xfer && (w_hunt_next == SYNC_BYTE)) w_next = ST_ADDR;  else w_next = ST_SYNC;
      ST_ADDR:  if (w_xfer && w_addr_last)                w_next = ST_DATA;  else w_next = ST_ADDR;
      ST_DATA:  if (w_xfer && w_data_last)                w_next = ST_PAR;   else w_next = ST_DATA;
      ST_PAR:   if (w_xfer)                               w_next = ST_CHECK; else w_next = ST_PAR;
      ST_CHECK: begin
        if (!w_par_ok)       w_next = ST_SYNC;
        else if (w_is_end)   w_next = ST_DONE;
        else if (!w_in_range) w_next = ST_SYNC;
        else                 w_next = ST_WRITE;
      end
      ST_WRITE: w_next = ST_SYNC;
      ST_DONE:  w_next = ST_DONE;
      default:  w_next = ST_SYNC;
    endcase
    if (restart) w_next = ST_SYNC;
    else         w_next = w_next;
  end

  // FSM state, sync hunt, status flags and the held write-port registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_SYNC;  r_ready <= 1'b1;  r_hunt  <= 8'd0;  r_par   <= 1'b0;
      r_we    <= 1'b0;     r_sel   <= 1'b0;  r_index <= 7'd0;  r_data  <= '0;
      r_done  <= 1'b0;     r_error <= 1'b0;  r_count <= 8'd0;
    end else if (restart) begin
      r_state <= ST_SYNC;  r_ready <= 1'b1;  r_hunt  <= 8'd0;  r_we <= 1'b0;
      r_done  <= 1'b0;     r_error <= 1'b0;  r_count <= 8'd0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_SYNC) || (w_next == ST_ADDR) ||
                 (w_next == ST_DATA) || (w_next == ST_PAR);
      r_we    <= (w_next == ST_WRITE);
      if (r_state != ST_SYNC) r_hunt <= 8'd0;
      else if (w_xfer)        r_hunt <= w_hunt_next;
      else                    r_hunt <= r_hunt;
      if ((r_state == ST_PAR) && w_xfer) r_par <= bs_data;
      else                               r_par <= r_par;
      if (w_next == ST_WRITE) begin
        r_sel   <= w_addr[7] ? SEL_SWITCH : SEL_TILE;
        r_index <= w_addr[6:0];
        r_data  <= w_data;
      end else begin
        r_sel   <= r_sel;
        r_index <= r_index;
        r_data  <= r_data;
      end
      if ((r_state == ST_CHECK) && (!w_par_ok || (!w_is_end && !w_in_range))) r_error <= 1'b1;
      else                                                                   r_error <= r_error;
      if ((r_state == ST_CHECK) && w_par_ok && w_is_end) r_done <= 1'b1;
      else                                               r_done <= r_done;
      if ((r_state == ST_WRITE) && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
      else                                             r_count <= r_count;
    end
  end

  // A restart landing on the strobe cycle must still block the fabric write.
  assign cfg_we      = r_we && !restart;
  assign bs_ready    = r_ready;
  assign cfg_sel     = r_sel;
  assign cfg_index   = r_index;
  assign cfg_data    = r_data;
  assign cfg_done    = r_done;
  assign cfg_error   = r_error;
  assign frame_count = r_count;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Randomised bench for fabric_config_loader with a frame-level reference model and per-cycle compare.
module tb_fabric_config_loader;

  logic        clock = 1'b0, reset_n = 1'b0, bs_data = 1'b0, bs_valid = 1'b0, restart = 1'b0;
  logic        bs_ready, cfg_we, cfg_sel, cfg_done, cfg_error;
  logic [6:0]  cfg_index;
  logic [32:0] cfg_data;
  logic [7:0]  frame_count;

  fabric_config_loader dut (
    .clock(clock), .reset_n(reset_n), .bs_data(bs_data), .bs_valid(bs_valid),
    .bs_ready(bs_ready), .restart(restart), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_index(cfg_index), .cfg_data(cfg_data), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int EV_WR = 0, EV_CNT = 1, EV_ERR = 2, EV_DONE = 3;
  typedef struct { int at; int kind; logic sel; logic [6:0] idx; logic [32:0] data; } ev_t;
  ev_t evq[$];

  logic        e_done, e_err, e_sel, e_we;
  logic [7:0]  e_cnt;
  logic [6:0]  e_idx;
  logic [32:0] e_data;
  int          busy_a, busy_b;
  logic [7:0]  m_win;
  int          m_nwin;
  bit          m_synced;
  logic        m_body[$];
  bit          rand_stall = 0;

  function automatic void push_ev(input int at, input int kind, input logic sel,
                                  input logic [6:0] idx, input logic [32:0] data);
    ev_t e;
    e.at = at; e.kind = kind; e.sel = sel; e.idx = idx; e.data = data;
    evq.push_back(e);
  endfunction

  function automatic void model_resync();
    m_synced = 0; m_nwin = 0; m_win = 8'd0; m_body.delete();
  endfunction

  function automatic void model_clear();
    evq.delete(); model_resync();
    e_done = 0; e_err = 0; e_cnt = 8'd0; e_sel = 0; e_idx = 7'd0; e_data = 33'd0;
    busy_a = -1; busy_b = -1;
  endfunction

  function automatic void model_restart(input int r);
    int i = 0;
    while (i < evq.size()) if (evq[i].at >= r) evq.delete(i); else i++;
    model_resync();
    e_done = 0; e_err = 0; e_cnt = 8'd0; busy_a = -1; busy_b = -1;
  endfunction

  // Whole-frame judgement: k is the cycle number right after the parity bit's edge.
  function automatic void model_frame(input int k);
    logic [7:0]  a = 8'd0;
    logic [32:0] d = 33'd0;
    int          idx;
    bit          ok_par, ok_rng;
    for (int i = 0; i < 8; i++)  a = {a[6:0], m_body[i]};
    for (int i = 8; i < 41; i++) d = {d[31:0], m_body[i]};
    ok_par = ($countones({a, d, m_body[41]}) % 2) == 0;
    idx    = int'(a) % 128;
    ok_rng = (a >= 8'd128) ? (idx < 9) : (idx < 24);
    busy_a = k; busy_b = -1;
    if (!ok_par)              push_ev(k + 1, EV_ERR, 1'b0, 7'd0, 33'd0);
    else if (a == 8'hFF)      push_ev(k + 1, EV_DONE, 1'b0, 7'd0, 33'd0);
    else if (!ok_rng)         push_ev(k + 1, EV_ERR, 1'b0, 7'd0, 33'd0);
    else begin
      push_ev(k + 1, EV_WR, a[7], a[6:0], d);
      push_ev(k + 2, EV_CNT, 1'b0, 7'd0, 33'd0);
      busy_b = k + 1;
    end
    model_resync();
  endfunction

  function automatic void model_bit(input logic b);
    if (!m_synced) begin
      m_win = {m_win[6:0], b}; m_nwin++;
      if (m_nwin >= 8 && m_win == 8'hA5) begin m_synced = 1; m_body.delete(); end
    end else begin
      m_body.push_back(b);
      if (m_body.size() == 42) model_frame(cyc);
    end
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clock) begin
    if (reset_n) begin
      int i;
      i = 0; e_we = 1'b0;
      while (i < evq.size()) begin
        if (evq[i].at <= cyc) begin
          case (evq[i].kind)
            EV_WR:   begin e_we = 1'b1; e_sel = evq[i].sel; e_idx = evq[i].idx; e_data = evq[i].data; end
            EV_CNT:  if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            EV_ERR:  e_err = 1'b1;
            EV_DONE: e_done = 1'b1;
            default: ;
          endcase
          evq.delete(i);
        end else i++;
      end
      chk("cfg_we", cfg_we, e_we);
      chk("cfg_sel", cfg_sel, e_sel);
      chk("cfg_index", cfg_index, e_idx);
      chk("cfg_data", cfg_data, e_data);
      chk("cfg_done", cfg_done, e_done);
      chk("cfg_error", cfg_error, e_err);
      chk("frame_count", frame_count, e_cnt);
      chk("bs_ready", bs_ready, !e_done && cyc != busy_a && cyc != busy_b);
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    bs_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    int   waits = 0;
    logic rdy;
    bit   acc = 0;
    if (rand_stall && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    while (!acc) begin
      @(negedge clock); #1;
      bs_valid = 1'b1; bs_data = b; rdy = bs_ready;
      @(posedge clock); #1;
      bs_valid = 1'b0;
      if (rdy) begin
        acc = 1; model_bit(b);
      end else begin
        waits++;
        if (waits > 6) begin
          total++; bad++;
          $display("FAIL ready_timeout: bs_ready low for %0d cycles, required high", waits);
          return;
        end
      end
    end
  endtask

  task automatic do_restart();
    @(negedge clock); #1;
    restart = 1'b1; bs_valid = 1'b1; bs_data = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0; bs_valid = 1'b0;
    model_restart(cyc);
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset_n = 1'b0; bs_valid = 1'b0;
    #1;
    chk("rst_we", cfg_we, 1'b0);        chk("rst_ready", bs_ready, 1'b1);
    chk("rst_done", cfg_done, 1'b0);    chk("rst_error", cfg_error, 1'b0);
    chk("rst_count", frame_count, 8'd0); chk("rst_data", cfg_data, 33'd0);
    chk("rst_index", cfg_index, 7'd0);  chk("rst_sel", cfg_sel, 1'b0);
    model_clear();
    @(negedge clock); #1;
    reset_n = 1'b1;
  endtask

  function automatic logic gp(input logic [7:0] a, input logic [32:0] d);
    return logic'($countones({a, d}) % 2);
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [32:0] d, input logic p,
                            input int ngarb, input logic [7:0] garb, input int stall_at,
                            input int abort_at, input bit abort_rst);
    logic        bits[$];
    logic [49:0] fr;
    for (int i = ngarb - 1; i >= 0; i--) bits.push_back(garb[i]);
    fr = {8'hA5, a, d, p};
    for (int i = 49; i >= 0; i--) bits.push_back(fr[i]);
    for (int i = 0; i < bits.size(); i++) begin
      if (i == abort_at) begin
        if (abort_rst) do_reset(); else do_restart();
        return;
      end
      if (i == stall_at) idle(5);
      send_bit(bits[i]);
    end
    if (abort_at == bits.size()) begin
      if (abort_rst) do_reset(); else do_restart();
    end
  endtask

  task automatic good(input logic [7:0] a, input logic [32:0] d);
    send_frame(a, d, gp(a, d), 0, 8'd0, -1, -1, 0);
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a;
    logic [32:0] d;
    int          cat;
    model_clear();
    #12;
    chk("reset_ready", bs_ready, 1'b1);
    chk("reset_we", cfg_we, 1'b0);
    chk("reset_count", frame_count, 8'd0);
    @(negedge clock); #1 reset_n = 1'b1;

    // Tile frame, then switch frame behind garbage 1,0,1.
    send_frame(8'h03, 33'h1_000000FF, 1'b1, 0, 8'd0, -1, -1, 0);
    idle(3);
    chk("t1_data", cfg_data, 33'h1_000000FF); chk("t1_index", cfg_index, 7'd3);
    chk("t1_sel", cfg_sel, 1'b0); chk("t1_count", frame_count, 8'd1); chk("t1_err", cfg_error, 1'b0);
    send_frame(8'h82, 33'h0_0000F00F, 1'b0, 3, 8'b101, -1, -1, 0);
    idle(3);
    chk("sw_sel", cfg_sel, 1'b1); chk("sw_index", cfg_index, 7'd2);
    chk("sw_data", cfg_data[15:0], 16'hF00F); chk("sw_count", frame_count, 8'd2);

    // Top-of-range indices, with a 5-cycle valid stall in the middle of DATA.
    send_frame(8'h17, 33'h1_2345_6789, gp(8'h17, 33'h1_2345_6789), 0, 8'd0, 30, -1, 0);
    good(8'h88, 33'h0_0000_0001);
    idle(3);
    chk("max_sw_index", cfg_index, 7'd8); chk("max_count", frame_count, 8'd4);

    // Reset in the middle of DATA.
    send_frame(8'h05, 33'h0_AAAA_5555, gp(8'h05, 33'h0_AAAA_5555), 0, 8'd0, -1, 35, 1);

    // Bad parity, then a good frame.
    send_frame(8'h03, 33'h1_000000FF, 1'b0, 0, 8'd0, -1, -1, 0);
    idle(3);
    chk("bp_err", cfg_error, 1'b1); chk("bp_count", frame_count, 8'd0); chk("bp_data", cfg_data, 33'd0);
    good(8'h04, 33'h0_1357_9BDF);
    idle(3);
    chk("bp_next_count", frame_count, 8'd1); chk("bp_next_index", cfg_index, 7'd4);

    // Range errors.
    do_restart(); good(8'h18, 33'h0_0000_0000); idle(3);
    chk("rng_tile_err", cfg_error, 1'b1); chk("rng_tile_count", frame_count, 8'd0);
    do_restart(); good(8'h89, 33'h0_0000_0003); idle(3);
    chk("rng_sw_err", cfg_error, 1'b1); chk("rng_sw_count", frame_count, 8'd0);

    // END with wrong parity is an error; END with even parity completes.
    do_restart();
    send_frame(8'hFF, 33'd0, 1'b1, 0, 8'd0, -1, -1, 0); idle(3);
    chk("end_bad_done", cfg_done, 1'b0); chk("end_bad_err", cfg_error, 1'b1);
    send_frame(8'hFF, 33'd0, 1'b0, 0, 8'd0, -1, -1, 0); idle(4);
    chk("end_done", cfg_done, 1'b1); chk("end_ready", bs_ready, 1'b0);
    do_restart(); idle(1);
    chk("rs_done", cfg_done, 1'b0); chk("rs_count", frame_count, 8'd0);
    chk("rs_ready", bs_ready, 1'b1); chk("rs_err", cfg_error, 1'b0);

    // Restart on the CHECK cycle suppresses the write.
    send_frame(8'h07, 33'h1_FFFF_0000, gp(8'h07, 33'h1_FFFF_0000), 0, 8'd0, -1, 50, 0);
    idle(3);
    chk("rs_check_count", frame_count, 8'd0);

    // Saturation of frame_count.
    for (int n = 0; n < 258; n++) good(8'($urandom_range(0, 23)), {1'($urandom), 32'($urandom)});
    idle(3);
    chk("sat_count", frame_count, 8'hFF);

    // Random mix with stalls, garbage and aborted frames.
    do_restart();
    rand_stall = 1;
    for (int n = 0; n < 40; n++) begin
      cat = $urandom_range(0, 9);
      d   = {1'($urandom), 32'($urandom)};
      case (cat)
        0, 1, 2, 3: a = 8'($urandom_range(0, 23));
        4, 5, 6:    a = 8'h80 | 8'($urandom_range(0, 8));
        7:          a = 8'($urandom_range(24, 127));
        8:          a = 8'h80 | 8'($urandom_range(9, 126));
        default:    a = 8'($urandom_range(0, 23));
      endcase
      send_frame(a, d, (cat == 9) ? ~gp(a, d) : gp(a, d), $urandom_range(0, 4), 8'd0, -1,
                 ($urandom_range(0, 9) == 0) ? $urandom_range(0, 50) : -1, 0);
    end
    rand_stall = 0;
    send_frame(8'hFF, 33'd0, 1'b0, 0, 8'd0, -1, -1, 0);
    idle(4);
    chk("final_done", cfg_done, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
